reg_bank_arbiter: RTL

Shares the single configuration/status register bank between the SPI and I2C peripheral front-ends.
- Each requester claims ownership with a transaction-level lock. The arbiter grants one owner at a time, round-robin on ties, and serialises that owner's word accesses onto the bank port.
- An inactivity timeout recovers the bank from a stuck owner.
- It sits between the protocol engines and the register bank, alongside the synchronizers, inside spi_wrapper.

---
 rtl/reg_bank_arb_pkg.sv | 11 +
 rtl/arb_timeout_counter.sv | 33 +++
 rtl/reg_bank_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_bank_arb_pkg.sv
// Shared types and default widths for the register-bank arbiter.
package reg_bank_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 3;
  localparam int unsigned DEF_REG_WIDTH  = 8;

  typedef enum logic [1:0] {OWN_NONE, OWN_SPI, OWN_I2C} owner_e;

  typedef enum logic [1:0] {ST_IDLE, ST_OWN_SPI, ST_OWN_I2C} arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Idle-cycle counter for a held bank lock; expired asserts at TIMEOUT_CYCLES (0 disables).
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW        = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
  localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (ena) begin
      if (clear || TIMEOUT_CYCLES == 0) begin
        cnt <= '0;
      end else if (inc && cnt != LIMIT) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/reg_bank_arbiter.sv
// Lock-based SPI/I2C arbiter for the shared config/status register bank.
// Optional REG_BANK_ARB_FORCE_SEL_EN adds a sel input forcing the eligible owner.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned REG_WIDTH      = DEF_REG_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  spi_lock,
  input  logic                  spi_req,
  input  logic                  spi_we,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  input  logic [REG_WIDTH-1:0]  spi_wdata,
  input  logic                  i2c_lock,
  input  logic                  i2c_req,
  input  logic                  i2c_we,
  input  logic [ADDR_WIDTH-1:0] i2c_addr,
  input  logic [REG_WIDTH-1:0]  i2c_wdata,
  output logic                  spi_gnt,
  output logic                  spi_ack,
  output logic                  i2c_gnt,
  output logic                  i2c_ack,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  bank_en,
  output logic                  bank_we,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  output logic [REG_WIDTH-1:0]  bank_wdata,
  input  logic [REG_WIDTH-1:0]  bank_rdata,
`ifdef REG_BANK_ARB_FORCE_SEL_EN
  input  logic                  sel,
`endif
  input  logic                  timeout_clr,
  output logic                  timeout_flag
);

  arb_state_e state, next_state;
  owner_e     last_owner;
  logic       pending, spi_bar, i2c_bar;
  logic       spi_sel_ok, i2c_sel_ok, spi_elig, i2c_elig;
  logic       owned, start, force_rel, expired, tmo_inc, tmo_clear;
  logic       own_req, own_lock, own_ok, own_we;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [REG_WIDTH-1:0]  own_wdata;

  always_comb begin
    spi_sel_ok = 1'b1;
    i2c_sel_ok = 1'b1;
`ifdef REG_BANK_ARB_FORCE_SEL_EN
    spi_sel_ok = ~sel;
    i2c_sel_ok = sel;
`endif
    spi_elig = spi_lock & ~spi_bar & spi_sel_ok;
    i2c_elig = i2c_lock & ~i2c_bar & i2c_sel_ok;

    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_ok    = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (state)
      ST_OWN_SPI: begin
        own_req = spi_req; own_lock = spi_lock; own_ok = spi_sel_ok;
        own_we = spi_we; own_addr = spi_addr; own_wdata = spi_wdata;
      end
      ST_OWN_I2C: begin
        own_req = i2c_req; own_lock = i2c_lock; own_ok = i2c_sel_ok;
        own_we = i2c_we; own_addr = i2c_addr; own_wdata = i2c_wdata;
      end
      default: ;
    endcase

    owned      = (state != ST_IDLE);
    next_state = state;
    start      = 1'b0;
    force_rel  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (spi_elig && i2c_elig)
          next_state = (last_owner == OWN_SPI) ? ST_OWN_I2C : ST_OWN_SPI;
        else if (spi_elig)
          next_state = ST_OWN_SPI;
        else if (i2c_elig)
          next_state = ST_OWN_I2C;
      end
      default: begin
        // A pending access always completes; a request beats release so an
        // owner dropping lock alongside its last req still gets served.
        if (pending) begin
          next_state = state;
        end else if (expired) begin
          next_state = ST_IDLE;
          force_rel  = 1'b1;
        end else if (own_req && own_ok) begin
          start = 1'b1;
        end else if (!own_lock || !own_ok) begin
          next_state = ST_IDLE;
        end
      end
    endcase

    tmo_inc   = owned & ~own_req & ~pending;
    tmo_clear = ~owned | own_req | force_rel;
  end

  arb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .clear   (tmo_clear),
    .inc     (tmo_inc),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      last_owner   <= OWN_I2C;
      pending      <= 1'b0;
      spi_bar      <= 1'b0;
      i2c_bar      <= 1'b0;
      spi_gnt      <= 1'b0;
      i2c_gnt      <= 1'b0;
      spi_ack      <= 1'b0;
      i2c_ack      <= 1'b0;
      rdata        <= '0;
      bank_en      <= 1'b0;
      bank_we      <= 1'b0;
      bank_addr    <= '0;
      bank_wdata   <= '0;
      timeout_flag <= 1'b0;
    end else if (ena) begin
      pending <= start;
      bank_en <= start;
      bank_we <= start & own_we;
      if (start) begin
        bank_addr  <= own_addr;
        bank_wdata <= own_wdata;
      end
      spi_ack <= pending & (state == ST_OWN_SPI);
      i2c_ack <= pending & (state == ST_OWN_I2C);
      if (pending) rdata <= bank_rdata;
      spi_gnt <= (next_state == ST_OWN_SPI);
      i2c_gnt <= (next_state == ST_OWN_I2C);
      if (owned && next_state == ST_IDLE)
        last_owner <= (state == ST_OWN_SPI) ? OWN_SPI : OWN_I2C;
      if (force_rel && state == ST_OWN_SPI) spi_bar <= 1'b1;
      else if (!spi_lock)                   spi_bar <= 1'b0;
      if (force_rel && state == ST_OWN_I2C) i2c_bar <= 1'b1;
      else if (!i2c_lock)                   i2c_bar <= 1'b0;
      if (force_rel)        timeout_flag <= 1'b1;
      else if (timeout_clr) timeout_flag <= 1'b0;
    end
  end

endmodule
